// File: rtl/a0_uart_tx_pkg.sv
// Shared types and constants for the a0 UART debug transmitter.
// Pure declarations: no logic, no latency, no flow control.
package a0_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

endpackage

// File: rtl/a0_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO. dout is the head word with zero read latency; count updates one edge after push/pop.
// Push while full is accepted only when a pop happens on the same edge; otherwise it is ignored. Pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still legal then.
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/a0_uart_tx.sv
// Queues each new a0 value and sends it as a 4-byte 8N1 UART frame, MSB byte first; tx falls one edge after the push.
// No backpressure upstream: a change arriving while the FIFO is full is dropped and flagged in sticky overflow.
module a0_uart_tx
    import a0_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DATA_WIDTH-1:0]         a0,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [DATA_WIDTH-1:0] r_prev_a0;
    logic                  r_overflow;
    state_t                r_state, w_state_nxt;
    logic [1:0]            r_byte_idx, w_byte_idx_nxt;
    logic [2:0]            r_bit_idx, w_bit_idx_nxt;
    logic [CW-1:0]         r_baud_cnt, w_baud_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_tx, w_tx_nxt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_baud_last;
    logic [7:0]            w_cur_byte;

    assign w_push = en && (a0 != r_prev_a0);
    assign w_pop  = (r_state == IDLE) && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (a0),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_count)
    );

    // A drop on the same edge as clr_ovf keeps the flag set so the loss is not hidden.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_prev_a0  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_prev_a0 <= a0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign w_baud_last = (r_baud_cnt == CW'(CLKS_PER_BIT-1));
    assign w_cur_byte  = r_shift[DATA_WIDTH-1 -: BITS_PER_BYTE];

    always_comb begin
        w_state_nxt    = r_state;
        w_byte_idx_nxt = r_byte_idx;
        w_bit_idx_nxt  = r_bit_idx;
        w_baud_cnt_nxt = r_baud_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_nxt    = START;
                    w_shift_nxt    = w_head;
                    w_byte_idx_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_baud_cnt_nxt = '0;
                    w_tx_nxt       = 1'b0;
                end
            end
            START: begin
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    w_bit_idx_nxt  = '0;
                    w_state_nxt    = DATA;
                    w_tx_nxt       = w_cur_byte[0];
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CW'(1);
                end
            end
            DATA: begin
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    if (r_bit_idx == 3'(BITS_PER_BYTE-1)) begin
                        w_state_nxt = STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_cur_byte[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CW'(1);
                end
            end
            STOP: begin
                if (w_baud_last) begin
                    w_baud_cnt_nxt = '0;
                    if (r_byte_idx != 2'(BYTES_PER_WORD-1)) begin
                        // Next byte moves into the top of the shift register; no idle gap.
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_shift_nxt    = r_shift << BITS_PER_BYTE;
                        w_state_nxt    = START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_baud_cnt_nxt = r_baud_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    assign tx       = r_tx;
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;

endmodule
